seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Drives a 4-digit, common-anode seven-segment display from the stopwatch counter's BCD outputs (`min1`, `min0`, `sec1`, `sec0`). It time-multiplexes the digits and snapshots the counter once per scan so a digit never changes mid-scan. In adjust mode it blinks the selected digit pair. It sits between the counter and the board's anode and cathode pins and is the consumer end of the counter's digit interface.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles each digit is lit; must be ≥ 2.
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `min1`  in  4  BCD tens of minutes.
- `min0`  in  4  BCD units of minutes.
- `sec1`  in  4  BCD tens of seconds.
- `sec0`  in  4  BCD units of seconds.
- `adjust`  in  2  nonzero means adjust mode.
- `select`  in  1  adjust target: 0 = minutes (digits 3,2), 1 = seconds (digits 1,0).
- `an`  out  4  active-low anodes; `an[0]` = `sec0` … `an[3]` = `min1`.
- `seg`  out  7  active-low cathodes, {g,f,e,d,c,b,a}.
- `dp`  out  1  active-low decimal point.

## Operation
- **Refresh counter:** `rcnt` counts 0..`REFRESH_DIV`-1 and wraps.
- **Digit index:** `idx` (0..3, 2 bits) increments mod 4 when `rcnt` wraps. Scan order is 0,1,2,3,0…
- **Snapshot:** all four inputs are loaded into `snap` on every cycle where `rcnt`==0 and `idx`==0. Input changes at any other time are invisible until the next such cycle.
- **Blink:** `bcnt` counts 0..`BLINK_DIV`-1. `phase` toggles when `bcnt` wraps, and phase 0 means visible. While `adjust`==0, `bcnt` is held at 0 and `phase` at 0. Entering adjust mode therefore starts with a full visible half-period.
- **Digit blanking:** a digit is blank when `phase`==1, `adjust`≠0, and the digit belongs to the group chosen by `select`. Blank means its `an` bit is 1, `seg`=7'h7F and `dp`=1.
- **Decode:** 0–9 map to standard patterns, e.g. 0=7'b1000000, 4=7'b0011001, 8=7'b0000000. Values 10–15 display a dash, 7'b0111111.
- **Separator:** `dp`=0 while digit 2 is lit, giving MM.SS. Otherwise `dp`=1.
- **One-hot anodes:** exactly one `an` bit is low at any time, unless that digit is blank or the block is in reset.
- `select` and `adjust` are sampled every cycle; they are not snapshotted.
- **Reset:** `reset`=0 at a clk edge forces `rcnt`, `idx`, `bcnt`, `phase` and `snap` to 0. It also forces `an`=4'b1111, `seg`=7'h7F and `dp`=1. This applies mid-scan or mid-blink as well; there is no partial state.

## Timing
- All outputs are registered.
- Outputs at edge t reflect `idx`, `snap`, `phase`, `adjust` and `select` as held before edge t.
- **After reset release:**
  - At the first active edge, E1, `snap` loads and the outputs are still blank.
  - From E2, digit 0 is lit (`an`=4'b1110) with the value sampled at E1.
- Input-to-display latency is 2 cycles, measured from the snapshot-load cycle.
- Each digit stays lit for exactly `REFRESH_DIV` cycles. A full scan takes 4×`REFRESH_DIV` cycles.
- A blink half-period is exactly `BLINK_DIV` cycles. It is not aligned to the scan.

## Configuration
- **`LEADING_ZERO_BLANK_EN`:**
  - Defined: digit 3 is blanked whenever `snap` `min1`==0, giving `an[3]`=1 and `seg`=7'h7F during its slot.
  - Undefined: a leading zero is shown as 0 (7'b1000000).
  - The blink and reset rules are identical in both builds.

## Test plan
All scenarios use `REFRESH_DIV`=4 and `BLINK_DIV`=16.
- **Reset:** hold `reset`=0 for 3 cycles, then release with digits 1,2,3,4 applied → `an`=1111, `seg`=7F, `dp`=1 through E1. At E2, `an`=1110 and `seg`=7'b0011001.
- **Scan:** with `min1`=1, `min0`=2, `sec1`=3, `sec0`=4 → `an` steps 1110→1101→1011→0111, 4 cycles each. `seg` shows 4, 3 (7'b0110000), 2, 1 in turn. `dp`=0 only while `an`=1011.
- **No tearing:** change `sec1` from 3 to 7 while digit 0 is lit → digit 1 still shows 3 this scan and shows 7 on the next scan.
- **Blink:** `adjust`=2'b01, `select`=0 → visible for 16 cycles, then for 16 cycles `an[3:2]` stay 1 while digits 0 and 1 keep scanning. Setting `adjust`=0 makes all digits visible on the next output edge.
- **Invalid BCD:** `sec0`=4'hC → `seg`=7'b0111111 during the digit-0 slot.
- **Macro:** `min1`=0 → with `LEADING_ZERO_BLANK_EN`, `an`=1111 during the digit-3 slot. Without it, `an`=0111 and `seg`=7'b1000000.

Source files
------------

// File: rtl/seg_display_mux.sv
// 4-digit common-anode seven-segment scanner with a once-per-scan input snapshot and adjust-mode blink.
// Optional macro LEADING_ZERO_BLANK_EN hides digit 3 when the snapped tens-of-minutes value is zero.
module seg_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [1:0] adjust,
    input  logic       select,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    logic [RW-1:0]     rcnt;
    logic [1:0]        idx;
    logic [BW-1:0]     bcnt;
    logic              phase;
    logic [3:0][3:0]   snap;   // [3]=min1 .. [0]=sec0, matching anode order
    logic              live;   // low for the first edge after reset so E1 stays blank

    logic              blank;
    logic              lz_blank;
    logic [3:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = (idx == 2'd3) && (snap[3] == 4'd0);
`else
        lz_blank = 1'b0;
`endif
        // select=0 targets the minutes pair (idx 3,2); select=1 the seconds pair (idx 1,0)
        blank = !live || lz_blank ||
                (phase && (adjust != 2'b00) && (idx[1] == ~select));
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = decode(snap[idx]);
            dp_d  = (idx != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt  <= '0;
            idx   <= 2'd0;
            bcnt  <= '0;
            phase <= 1'b0;
            snap  <= '0;
            live  <= 1'b0;
            an    <= 4'hF;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            live <= 1'b1;
            if (rcnt == RMAX) begin
                rcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            if (rcnt == '0 && idx == 2'd0)
                snap <= {min1, min0, sec1, sec0};
            // leaving adjust mode parks the blink so re-entry starts with a full visible half-period
            if (adjust == 2'b00) begin
                bcnt  <= '0;
                phase <= 1'b0;
            end else if (bcnt == BMAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end
endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with REFRESH_DIV=4, BLINK_DIV=16; edge k counts clk edges since reset release.
module tb_seg_display_mux;
    logic       clk;
    logic       reset;
    logic [3:0] min1, min0, sec1, sec0;
    logic [1:0] adjust;
    logic       select;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S7 = 7'h78, DASH = 7'h3F, BLK = 7'h7F;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [15:0] din;   // {min1,min0,sec1,sec0} driven after the check
    } vec_t;
    vec_t vt[$];

    seg_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .reset(reset),
        .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
        .adjust(adjust), .select(select),
        .an(an), .seg(seg), .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: got %h, want %h", nm, k, act, exp);
        end
    endtask

    task automatic add(input int kk, input logic [3:0] a, input logic [6:0] s,
                       input logic d, input logic [15:0] din);
        vec_t v;
        v.k = kk; v.an = a; v.seg = s; v.dp = d; v.din = din;
        vt.push_back(v);
    endtask

    // Blink window is counted from the first edge at which adjust is already nonzero.
    task automatic blink_run(input int start, input int stop, input logic sel);
        int r, d;
        logic hide;
        logic [3:0] ea;
        while (k < stop) begin
            tick();
            r = k - start;
            d = ((k - 1) / 4) % 4;
            hide = (r >= 16 && r < 32) && ((d >= 2) != sel);
            ea = hide ? 4'hF : ~(4'b0001 << d);
            chk("blink_an", {3'b0, an}, {3'b0, ea});
            chk("blink_dp", {6'b0, dp}, {6'b0, (!hide && d == 2) ? 1'b0 : 1'b1});
            if (hide) chk("blink_seg", seg, BLK);
        end
    endtask

    initial begin
        reset = 1'b0;
        adjust = 2'b00;
        select = 1'b0;
        {min1, min0, sec1, sec0} = 16'h1234;

        add(1,  4'hF, BLK, 1, 16'h1234);
        add(2,  4'hE, S4,  1, 16'h1234);
        add(4,  4'hE, S4,  1, 16'h1234);
        add(5,  4'hD, S3,  1, 16'h1234);
        add(8,  4'hD, S3,  1, 16'h1234);
        add(9,  4'hB, S2,  0, 16'h1234);
        add(12, 4'hB, S2,  0, 16'h1234);
        add(13, 4'h7, S1,  1, 16'h1234);
        add(16, 4'h7, S1,  1, 16'h1234);
        add(17, 4'hE, S4,  1, 16'h1234);
        add(18, 4'hE, S4,  1, 16'h1274);   // sec1 -> 7 mid-scan
        add(21, 4'hD, S3,  1, 16'h1274);
        add(24, 4'hD, S3,  1, 16'h1274);
        add(33, 4'hE, S4,  1, 16'h1274);
        add(37, 4'hD, S7,  1, 16'h1274);
        add(40, 4'hD, S7,  1, 16'h127C);   // sec0 -> invalid BCD
        add(49, 4'hE, S4,  1, 16'h127C);
        add(50, 4'hE, DASH, 1, 16'h127C);
        add(52, 4'hE, DASH, 1, 16'h1274);
        add(53, 4'hD, S7,  1, 16'h1274);
        add(57, 4'hB, S2,  0, 16'h1274);
        add(61, 4'h7, S1,  1, 16'h1274);
        add(64, 4'h7, S1,  1, 16'h1274);

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_an", {3'b0, an}, 7'h0F);
            chk("rst_seg", seg, BLK);
            chk("rst_dp", {6'b0, dp}, 7'h01);
        end
        reset = 1'b1;
        k = 0;

        foreach (vt[i]) begin
            while (k < vt[i].k) tick();
            chk("vec_an", {3'b0, an}, {3'b0, vt[i].an});
            chk("vec_seg", seg, vt[i].seg);
            chk("vec_dp", {6'b0, dp}, {6'b0, vt[i].dp});
            {min1, min0, sec1, sec0} = vt[i].din;
        end

        adjust = 2'b01;
        select = 1'b0;
        blink_run(65, 89, 1'b0);
        adjust = 2'b00;
        tick();
        chk("unblink_an", {3'b0, an}, 7'h0B);
        chk("unblink_seg", seg, S2);
        chk("unblink_dp", {6'b0, dp}, 7'h00);

        adjust = 2'b01;
        select = 1'b1;
        blink_run(91, 120, 1'b1);
        adjust = 2'b00;
        select = 1'b0;
        min1 = 4'd0;

        while (k < 141) tick();
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_an", {3'b0, an}, 7'h0F);
        chk("lz_seg", seg, BLK);
`else
        chk("lz_an", {3'b0, an}, 7'h07);
        chk("lz_seg", seg, S0);
`endif
        while (k < 144) tick();
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_an_end", {3'b0, an}, 7'h0F);
`else
        chk("lz_an_end", {3'b0, an}, 7'h07);
`endif
        tick();
        chk("after_lz_an", {3'b0, an}, 7'h0E);

        // reset partway through a digit slot
        while (k < 146) tick();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_an", {3'b0, an}, 7'h0F);
        chk("midrst_seg", seg, BLK);
        chk("midrst_dp", {6'b0, dp}, 7'h01);
        reset = 1'b1;
        k = 0;
        tick();
        chk("rel_e1_an", {3'b0, an}, 7'h0F);
        tick();
        chk("rel_e2_an", {3'b0, an}, 7'h0E);
        chk("rel_e2_seg", seg, S4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
